// File: rtl/dmul_sched_pkg.sv
// Shared types for the double multiplier scheduler: data width and FSM state encoding.
package dmul_sched_pkg;

   localparam int DW = 64;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SEND    = 2'd1,
      S_WAIT_Z  = 2'd2,
      S_DELIVER = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               gnt_vld,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic [NUM_REQ-1:0] gnt_oh
);

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
      return IDX_W'((int'(base) + k) % NUM_REQ);
   endfunction

   logic [IDX_W-1:0] cand;

   // Walk the offsets from farthest to nearest so the nearest hit is the one that sticks.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      cand    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = wrap_idx(ptr, k);
         if (req[cand]) begin
            gnt_vld      = 1'b1;
            gnt_idx      = cand;
            gnt_oh       = '0;
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/double_mult_scheduler.sv
// Shares one stb/ack double multiplier between NUM_REQ requesters with round-robin grant.
// Latency: grant -> mul stb next cycle; mul_z transfer -> res_stb next cycle.
// Backpressure: one op in flight; others wait unacked until the owner takes its product.
module double_mult_scheduler
   import dmul_sched_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_stb,
   input  logic [DW*NUM_REQ-1:0] req_a,
   input  logic [DW*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ack,
   output logic [DW-1:0]         res_z,
   output logic [NUM_REQ-1:0]    res_stb,
   input  logic [NUM_REQ-1:0]    res_ack,
   output logic [DW-1:0]         mul_a,
   output logic                  mul_a_stb,
   input  logic                  mul_a_ack,
   output logic [DW-1:0]         mul_b,
   output logic                  mul_b_stb,
   input  logic                  mul_b_ack,
   input  logic [DW-1:0]         mul_z,
   input  logic                  mul_z_stb,
   output logic                  mul_z_ack,
   output logic                  busy
);

   state_t               state;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     g;
   logic                 gnt_vld;
   logic [IDX_W-1:0]     gnt_idx;
   logic [NUM_REQ-1:0]   gnt_oh;
   logic [NUM_REQ-1:0]   g_oh;
   logic [DW-1:0]        sel_a;
   logic [DW-1:0]        sel_b;
   logic                 a_left;
   logic                 b_left;
   logic                 owner_ack;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (req_stb),
      .ptr     (rr_ptr),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .gnt_oh  (gnt_oh)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      g_oh  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            sel_a = req_a[i*DW +: DW];
            sel_b = req_b[i*DW +: DW];
         end
         g_oh[i] = (g == IDX_W'(i));
      end
   end

   // A strobe is still outstanding unless the core takes it on this edge.
   assign a_left    = mul_a_stb && !mul_a_ack;
   assign b_left    = mul_b_stb && !mul_b_ack;
   assign owner_ack = |(res_ack & g_oh);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         g         <= '0;
         req_ack   <= '0;
         res_stb   <= '0;
         res_z     <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_a_stb <= 1'b0;
         mul_b_stb <= 1'b0;
         mul_z_ack <= 1'b0;
      end else begin
         req_ack <= '0;
         case (state)
            S_IDLE: begin
               if (gnt_vld) begin
                  mul_a     <= sel_a;
                  mul_b     <= sel_b;
                  mul_a_stb <= 1'b1;
                  mul_b_stb <= 1'b1;
                  req_ack   <= gnt_oh;
                  g         <= gnt_idx;
                  state     <= S_SEND;
               end
            end
            S_SEND: begin
               mul_a_stb <= a_left;
               mul_b_stb <= b_left;
               if (!a_left && !b_left) begin
                  mul_z_ack <= 1'b1;
                  state     <= S_WAIT_Z;
               end
            end
            S_WAIT_Z: begin
               if (mul_z_stb && mul_z_ack) begin
                  res_z     <= mul_z;
                  mul_z_ack <= 1'b0;
                  res_stb   <= g_oh;
                  state     <= S_DELIVER;
               end
            end
            S_DELIVER: begin
               if (owner_ack) begin
                  res_stb <= '0;
                  rr_ptr  <= (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_double_mult_scheduler.sv
// Bench for double_mult_scheduler: directed scenarios plus a randomized run against a
// queue-free round-robin/product reference, with a behavioural stb/ack multiplier core.
module tb_double_mult_scheduler;

   localparam int N = 2;
   localparam logic [63:0] D1P5 = 64'h3FF8000000000000;
   localparam logic [63:0] D2   = 64'h4000000000000000;
   localparam logic [63:0] D3   = 64'h4008000000000000;
   localparam logic [63:0] DM2  = 64'hC000000000000000;
   localparam logic [63:0] DP5  = 64'h3FE0000000000000;
   localparam logic [63:0] DM1  = 64'hBFF0000000000000;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_stb, req_ack, res_stb, res_ack;
   logic [64*N-1:0] req_a, req_b;
   logic [63:0]     res_z, mul_a, mul_b, mul_z;
   logic            mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack, mul_z_stb, mul_z_ack, busy;

   int total = 0;
   int bad   = 0;
   int a_dly = 0;
   int b_dly = 0;
   int z_dly = 2;

   always #5 clk = ~clk;

   double_mult_scheduler #(.NUM_REQ(N), .IDX_W(1)) dut (
      .clk(clk), .rst(rst),
      .req_stb(req_stb), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
      .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
      .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
      .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
      .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
      .busy(busy)
   );

   function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) * $bitstoreal(b));
   endfunction

   function automatic logic [63:0] rand_dbl();
      logic [63:0] v;
      v[63]    = 1'($urandom_range(0, 1));
      v[62:52] = 11'($urandom_range(990, 1056));
      v[51:32] = 20'($urandom);
      v[31:0]  = $urandom;
      return v;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Behavioural multiplier core: acks each operand after a programmable delay,
   // then presents the IEEE product z_dly cycles after both operands arrived.
   initial begin : core
      logic        got_a, got_b, la_stb, lb_stb, lz_ack, r;
      logic [63:0] la, lb, ca, cb;
      int          a_cnt, b_cnt, z_cnt;
      mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; mul_z = '0;
      got_a = 0; got_b = 0; la_stb = 0; lb_stb = 0; lz_ack = 0;
      la = '0; lb = '0; ca = '0; cb = '0; a_cnt = 0; b_cnt = 0; z_cnt = 0;
      forever begin
         @(posedge clk);
         r = rst;
         @(negedge clk);
         if (r) begin
            got_a = 0; got_b = 0; a_cnt = 0; b_cnt = 0; z_cnt = 0;
            mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0;
         end else begin
            if (la_stb && mul_a_ack) begin got_a = 1; ca = la; mul_a_ack = 0; a_cnt = 0; end
            if (lb_stb && mul_b_ack) begin got_b = 1; cb = lb; mul_b_ack = 0; b_cnt = 0; end
            if (mul_z_stb && lz_ack) mul_z_stb = 0;
            if (mul_a_stb && !got_a && !mul_a_ack) begin
               if (a_cnt >= a_dly) mul_a_ack = 1; else a_cnt++;
            end
            if (mul_b_stb && !got_b && !mul_b_ack) begin
               if (b_cnt >= b_dly) mul_b_ack = 1; else b_cnt++;
            end
            if (got_a && got_b) begin
               if (z_cnt >= z_dly) begin
                  mul_z = fmul(ca, cb); mul_z_stb = 1; got_a = 0; got_b = 0; z_cnt = 0;
               end else z_cnt++;
            end
         end
         la_stb = mul_a_stb; la = mul_a; lb_stb = mul_b_stb; lb = mul_b; lz_ack = mul_z_ack;
      end
   end

   task automatic wait_ack(output logic [N-1:0] a);
      int c = 0;
      do begin @(negedge clk); c++; end while (req_ack == '0 && c < 40);
      a = req_ack;
   endtask

   task automatic take_result(output logic [N-1:0] s, output logic [63:0] z);
      int c = 0;
      do begin @(negedge clk); c++; end while (res_stb == '0 && c < 80);
      s = res_stb;
      z = res_z;
      if (res_stb != '0) begin
         res_ack = res_stb;
         @(negedge clk);
         res_ack = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1; req_stb = '1; res_ack = '0;
      req_a = {rand_dbl(), rand_dbl()}; req_b = {rand_dbl(), rand_dbl()};
      repeat (5) begin
         @(negedge clk);
         total++;
         if ({req_ack, res_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy} !== '0 ||
             mul_a !== '0 || mul_b !== '0 || res_z !== '0) begin
            bad++;
            $display("FAIL reset: req_ack=%b res_stb=%b stb_a/b=%b%b z_ack=%b busy=%b mul_a=%h mul_b=%h res_z=%h, all required 0",
                     req_ack, res_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy, mul_a, mul_b, res_z);
         end
      end
      rst = 0; req_stb = '0;
   endtask

   task automatic test_single();
      int   acks = 0;
      bit   done = 0, res1 = 0;
      a_dly = 0; b_dly = 0; z_dly = 2;
      req_a[63:0] = D1P5; req_b[63:0] = D2; req_stb = 2'b01;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (req_ack != '0) begin
            acks++;
            total++;
            if (req_ack !== 2'b01 || mul_a_stb !== 1'b1 || mul_b_stb !== 1'b1 || mul_a !== D1P5 || mul_b !== D2) begin
               bad++;
               $display("FAIL single_grant: req_ack=%b stb=%b%b mul_a=%h mul_b=%h, required 01 11 %h %h",
                        req_ack, mul_a_stb, mul_b_stb, mul_a, mul_b, D1P5, D2);
            end
            req_stb = '0;
         end
         if (res_stb[1]) res1 = 1;
         if (res_stb != '0) begin
            total++;
            if (res_stb !== 2'b01 || res_z !== D3) begin
               bad++;
               $display("FAIL single_result: res_stb=%b res_z=%h, required 01 %h", res_stb, res_z, D3);
            end
            res_ack = 2'b01;
            done = 1;
         end
      end
      @(negedge clk);
      res_ack = '0;
      total++;
      if (acks != 1 || !done || res1) begin
         bad++;
         $display("FAIL single_count: req_ack pulses=%0d result_seen=%0d res_stb1_seen=%0d, required 1 1 0", acks, done, res1);
      end
      total++;
      if (res_stb !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_idle: res_stb=%b busy=%b, required 00 0", res_stb, busy);
      end
   endtask

   task automatic test_contention();
      logic [N-1:0] a, oh;
      logic [63:0]  e;
      int           extra, c;
      rst = 1; req_stb = 2'b11;
      req_a = {DM2, D1P5}; req_b = {DP5, D2};
      repeat (2) @(negedge clk);
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         oh = onehot(k % 2);
         e  = (k % 2 == 0) ? D3 : DM1;
         wait_ack(a);
         total++;
         if (a !== oh) begin
            bad++;
            $display("FAIL contention_grant%0d: req_ack=%b, required %b", k, a, oh);
         end
         extra = 0; c = 0;
         do begin @(negedge clk); c++; if (req_ack != '0) extra++; end while (res_stb == '0 && c < 60);
         res_ack = ~oh;
         @(negedge clk);
         @(negedge clk);
         total++;
         if (res_stb !== oh || res_z !== e || extra != 0) begin
            bad++;
            $display("FAIL contention_result%0d: res_stb=%b res_z=%h extra_acks=%0d, required %b %h 0",
                     k, res_stb, res_z, extra, oh, e);
         end
         res_ack = oh;
         @(negedge clk);
         res_ack = '0;
         total++;
         if (res_stb !== '0) begin
            bad++;
            $display("FAIL contention_release%0d: res_stb=%b, required 00", k, res_stb);
         end
      end
      req_stb = '0;
   endtask

   task automatic test_skew();
      logic [N-1:0] a, s;
      logic [63:0]  z;
      int           a_only = 0, c = 0;
      a_dly = 0; b_dly = 3; z_dly = 1;
      req_a[63:0] = D1P5; req_b[63:0] = D2; req_stb = 2'b01;
      wait_ack(a);
      req_stb = '0;
      do begin
         @(negedge clk); c++;
         if (mul_a_stb === 1'b0 && mul_b_stb === 1'b1 && mul_z_ack === 1'b0) a_only++;
      end while (mul_z_ack !== 1'b1 && c < 20);
      total++;
      if (a_only != 3 || mul_z_ack !== 1'b1 || mul_a_stb !== 1'b0 || mul_b_stb !== 1'b0) begin
         bad++;
         $display("FAIL skew_send: a_only_cycles=%0d z_ack=%b stb=%b%b, required 3 1 00",
                  a_only, mul_z_ack, mul_a_stb, mul_b_stb);
      end
      take_result(s, z);
      total++;
      if (s !== 2'b01 || z !== D3) begin
         bad++;
         $display("FAIL skew_result: res_stb=%b res_z=%h, required 01 %h", s, z, D3);
      end
      b_dly = 0;
   endtask

   task automatic test_backpressure();
      logic [N-1:0] a, s;
      logic [63:0]  z;
      int           c = 0, hold_bad = 0;
      z_dly = 1;
      req_a = {DM2, D1P5}; req_b = {DP5, D2}; req_stb = 2'b01;
      wait_ack(a);
      total++;
      if (a !== 2'b01) begin bad++; $display("FAIL bp_grant0: req_ack=%b, required 01", a); end
      req_stb = 2'b10;
      do begin @(negedge clk); c++; end while (res_stb == '0 && c < 60);
      repeat (20) begin
         @(negedge clk);
         if (res_stb !== 2'b01 || res_z !== D3 || busy !== 1'b1 || req_ack !== '0) hold_bad++;
      end
      total++;
      if (hold_bad != 0) begin
         bad++;
         $display("FAIL bp_hold: cycles_off=%0d last res_stb=%b res_z=%h busy=%b req_ack=%b, required 01 %h 1 00",
                  hold_bad, res_stb, res_z, busy, req_ack, D3);
      end
      res_ack = 2'b01;
      @(negedge clk);
      res_ack = '0;
      wait_ack(a);
      req_stb = '0;
      total++;
      if (a !== 2'b10) begin bad++; $display("FAIL bp_grant1: req_ack=%b, required 10", a); end
      take_result(s, z);
      total++;
      if (s !== 2'b10 || z !== DM1) begin
         bad++;
         $display("FAIL bp_result1: res_stb=%b res_z=%h, required 10 %h", s, z, DM1);
      end
   endtask

   task automatic test_reset_wait_z();
      logic [N-1:0] a, s;
      logic [63:0]  z;
      int           c = 0, leak = 0;
      z_dly = 30;
      req_a = {DM2, D1P5}; req_b = {DP5, D2}; req_stb = 2'b01;
      wait_ack(a);
      req_stb = '0;
      do begin @(negedge clk); c++; end while (mul_z_ack !== 1'b1 && c < 20);
      total++;
      if (mul_z_ack !== 1'b1) begin bad++; $display("FAIL rstz_reach: mul_z_ack=%b, required 1", mul_z_ack); end
      rst = 1;
      @(negedge clk);
      rst = 0;
      total++;
      if ({req_ack, res_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy} !== '0 || res_z !== '0) begin
         bad++;
         $display("FAIL rstz_clear: req_ack=%b res_stb=%b stb=%b%b z_ack=%b busy=%b res_z=%h, required all 0",
                  req_ack, res_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy, res_z);
      end
      z_dly = 1;
      repeat (40) begin
         @(negedge clk);
         if (res_stb !== '0 || busy !== 1'b0) leak++;
      end
      total++;
      if (leak != 0) begin bad++; $display("FAIL rstz_discard: cycles with res_stb/busy=%0d, required 0", leak); end
      req_stb = 2'b10;
      wait_ack(a);
      req_stb = '0;
      total++;
      if (a !== 2'b10) begin bad++; $display("FAIL rstz_regrant: req_ack=%b, required 10", a); end
      take_result(s, z);
      total++;
      if (s !== 2'b10 || z !== DM1) begin
         bad++;
         $display("FAIL rstz_result: res_stb=%b res_z=%h, required 10 %h", s, z, DM1);
      end
   endtask

   task automatic test_random();
      localparam int M = 3000;
      logic [N-1:0] prev_req, oh;
      logic [63:0]  ca[N], cb[N], exp_z[N];
      int           served[N];
      bit           inflight = 0, done_pend = 0, idle_prev = 1;
      int           owner = 0, last = N - 1, g;
      rst = 1; req_stb = '0; res_ack = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      prev_req = '0;
      for (int i = 0; i < N; i++) begin served[i] = 0; ca[i] = '0; cb[i] = '0; exp_z[i] = '0; end
      for (int cyc = 0; cyc < M + 400; cyc++) begin
         @(negedge clk);
         res_ack = '0;
         if (done_pend) begin
            total++;
            if (res_stb !== '0) begin bad++; $display("FAIL rand_release@%0d: res_stb=%b, required 00", cyc, res_stb); end
            inflight = 0; done_pend = 0; served[owner]++;
         end
         if (idle_prev && prev_req != '0) begin
            g = -1;
            for (int k = 0; k < N; k++)
               if (g < 0 && prev_req[(last + 1 + k) % N]) g = (last + 1 + k) % N;
            total++;
            if (req_ack !== onehot(g) || mul_a !== ca[g] || mul_b !== cb[g]) begin
               bad++;
               $display("FAIL rand_grant@%0d: req_ack=%b mul_a=%h mul_b=%h, required %b %h %h",
                        cyc, req_ack, mul_a, mul_b, onehot(g), ca[g], cb[g]);
            end
            inflight = 1; owner = g; last = g;
            exp_z[g] = fmul(ca[g], cb[g]);
            req_stb[g] = 1'b0;
            req_a[g*64 +: 64] = rand_dbl();
            req_b[g*64 +: 64] = rand_dbl();
            a_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3); z_dly = $urandom_range(0, 4);
         end else begin
            total++;
            if (req_ack !== '0) begin bad++; $display("FAIL rand_spurious_ack@%0d: req_ack=%b, required 00", cyc, req_ack); end
         end
         if (res_stb != '0) begin
            oh = onehot(owner);
            total++;
            if (!inflight || res_stb !== oh || res_z !== exp_z[owner]) begin
               bad++;
               $display("FAIL rand_result@%0d: res_stb=%b res_z=%h, required %b %h", cyc, res_stb, res_z, oh, exp_z[owner]);
            end else begin
               res_ack = N'($urandom) & ~oh;
               if ($urandom_range(0, 2) == 0) begin res_ack[owner] = 1'b1; done_pend = 1; end
            end
         end
         total++;
         if (busy !== inflight) begin bad++; $display("FAIL rand_busy@%0d: busy=%b, required %b", cyc, busy, inflight); end
         if (cyc < M) begin
            for (int i = 0; i < N; i++) begin
               if (!req_stb[i] && !(inflight && owner == i) && $urandom_range(0, 3) == 0) begin
                  ca[i] = rand_dbl(); cb[i] = rand_dbl();
                  req_a[i*64 +: 64] = ca[i]; req_b[i*64 +: 64] = cb[i];
                  req_stb[i] = 1'b1;
               end
            end
         end
         prev_req  = req_stb;
         idle_prev = !inflight;
         if (cyc >= M && !inflight && req_stb == '0) break;
      end
      total++;
      if (inflight || req_stb != '0) begin
         bad++;
         $display("FAIL rand_drain: inflight=%0d req_stb=%b, required 0 00", inflight, req_stb);
      end
      for (int i = 0; i < N; i++) begin
         total++;
         if (served[i] < 10) begin bad++; $display("FAIL rand_served%0d: ops=%0d, required >=10", i, served[i]); end
      end
      req_stb = '0; res_ack = '0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      req_stb = '0; req_a = '0; req_b = '0; res_ack = '0; rst = 1;
      test_reset();
      test_single();
      test_contention();
      test_skew();
      test_backpressure();
      test_reset_wait_z();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
